// File: rtl/ad7476a_emulator_pkg.sv
// Shared constants for the AD7476A emulator and its matching SPI master.
// State encodings, frame width and the datasheet timing figures.
package ad7476a_emulator_pkg;

    typedef enum logic [1:0] {
        IDLE  = 2'd0,
        SHIFT = 2'd1,
        DONE  = 2'd2,
        QUIET = 2'd3
    } state_t;

    localparam int FRAME_BITS = 16;

    // AD7476A timing in ns, also used by the master to pace cs_n/sclk.
    localparam int T2_NS             = 10;
    localparam int T8_PLUS_TQUIET_NS = 86;

endpackage

// File: rtl/ad7476a_emulator_if.sv
// Serial link between an AD7476A-style ADC and its master.
interface ad7476a_emulator_if;
    logic sclk;
    logic cs_n;
    logic sdata;
    logic sdata_oe;

    modport master (output sclk, output cs_n, input sdata, input sdata_oe);
    modport slave  (input sclk, input cs_n, output sdata, output sdata_oe);
endinterface

// File: rtl/ad7476a_emulator_sync_edge_detect.sv
// Multi-flop synchroniser for an asynchronous input plus rise/fall pulses.
// Resets to 1 so idle-high SPI lines produce no spurious edge after reset.
module sync_edge_detect #(
    parameter int STAGES = 2
) (
    input  logic clk_i,
    input  logic rst_i,
    input  logic d_i,
    output logic rise_o,
    output logic fall_o
);

    logic [STAGES-1:0] sync_q;
    logic              prev_q;

    always_ff @(posedge clk_i or posedge rst_i) begin
        if (rst_i) begin
            sync_q <= '1;
            prev_q <= 1'b1;
        end else begin
            sync_q <= {sync_q[STAGES-2:0], d_i};
            prev_q <= sync_q[STAGES-1];
        end
    end

    assign rise_o = sync_q[STAGES-1] & ~prev_q;
    assign fall_o = ~sync_q[STAGES-1] & prev_q;

endmodule

// File: rtl/ad7476a_emulator.sv
// AD7476A serial-output responder: captures sample_i on cs_n fall and shifts
// out LEAD_ZEROS zeros then the sample, MSB first, on synced sclk falls.
module ad7476a_emulator
    import ad7476a_emulator_pkg::*;
#(
    parameter int SYNC_STAGES  = 2,
    parameter int QUIET_CYCLES = 9,
    parameter int LEAD_ZEROS   = 4,
    parameter int DATA_BITS    = 12
) (
    input  logic                 clk_i,
    input  logic                 rst_i,
    input  logic [DATA_BITS-1:0] sample_i,
    ad7476a_emulator_if.slave    spi,
    output logic                 conv_start_o,
    output logic                 conv_done_o,
    output logic                 abort_o,
    output logic                 quiet_err_o
);

    localparam int FRAME = LEAD_ZEROS + DATA_BITS;

    state_t           state;
    logic [4:0]       cnt;
    logic [FRAME-1:0] sreg;
    logic [FRAME-1:0] frame_load;
    logic             sdata_q, oe_q;
    logic             sclk_fall, sclk_rise_unused;
    logic             cs_fall, cs_rise;
    logic             start;

    sync_edge_detect #(.STAGES(SYNC_STAGES)) u_sclk_sync (
        .clk_i (clk_i),
        .rst_i (rst_i),
        .d_i   (spi.sclk),
        .rise_o(sclk_rise_unused),
        .fall_o(sclk_fall)
    );

    sync_edge_detect #(.STAGES(SYNC_STAGES)) u_cs_sync (
        .clk_i (clk_i),
        .rst_i (rst_i),
        .d_i   (spi.cs_n),
        .rise_o(cs_rise),
        .fall_o(cs_fall)
    );

    assign frame_load = {{LEAD_ZEROS{1'b0}}, sample_i};
    // A restart during QUIET is still served; it only raises quiet_err_o.
    assign start      = cs_fall && (state == IDLE || state == QUIET);

    always_ff @(posedge clk_i or posedge rst_i) begin
        if (rst_i) begin
            state        <= IDLE;
            cnt          <= '0;
            sreg         <= '0;
            sdata_q      <= 1'b0;
            oe_q         <= 1'b0;
            conv_start_o <= 1'b0;
            conv_done_o  <= 1'b0;
            abort_o      <= 1'b0;
            quiet_err_o  <= 1'b0;
        end else begin
            conv_start_o <= 1'b0;
            conv_done_o  <= 1'b0;
            abort_o      <= 1'b0;
            quiet_err_o  <= 1'b0;
            if (start) begin
                quiet_err_o  <= (state == QUIET) && (cnt != 5'd0);
                conv_start_o <= 1'b1;
                sreg         <= frame_load;
                cnt          <= '0;
                oe_q         <= 1'b1;
                sdata_q      <= frame_load[FRAME-1];
                state        <= SHIFT;
            end else begin
                unique case (state)
                    IDLE: begin
                        oe_q    <= 1'b0;
                        sdata_q <= 1'b0;
                    end
                    SHIFT: begin
                        // cs_n edge wins over an sclk edge in the same cycle
                        if (cs_rise) begin
                            oe_q    <= 1'b0;
                            sdata_q <= 1'b0;
                            abort_o <= 1'b1;
                            cnt     <= 5'(QUIET_CYCLES);
                            state   <= QUIET;
                        end else if (sclk_fall) begin
                            sreg <= sreg << 1;
                            cnt  <= cnt + 5'd1;
                            if (cnt == 5'(FRAME - 1)) begin
                                oe_q        <= 1'b0;
                                sdata_q     <= 1'b0;
                                conv_done_o <= 1'b1;
                                state       <= DONE;
                            end else begin
                                sdata_q <= sreg[FRAME-2];
                            end
                        end
                    end
                    DONE: begin
                        if (cs_rise) begin
                            cnt   <= 5'(QUIET_CYCLES);
                            state <= QUIET;
                        end
                    end
                    QUIET: begin
                        if (cnt == 5'd0) state <= IDLE;
                        else             cnt   <= cnt - 5'd1;
                    end
                    default: state <= IDLE;
                endcase
            end
        end
    end

    assign spi.sdata    = sdata_q;
    assign spi.sdata_oe = oe_q;

endmodule

// File: tb/tb_ad7476a_emulator.sv
// Randomised bench for ad7476a_emulator acting as a simple SPI master.
// Expected frames come straight from {4 zeros, sample} read MSB first.
module tb_ad7476a_emulator;

    logic        clk = 1'b0;
    logic        rst = 1'b1;
    logic [11:0] sample = '0;
    logic        conv_start, conv_done, abort_p, quiet_err;

    ad7476a_emulator_if spi ();

    ad7476a_emulator #(
        .SYNC_STAGES (2),
        .QUIET_CYCLES(9),
        .LEAD_ZEROS  (4),
        .DATA_BITS   (12)
    ) dut (
        .clk_i       (clk),
        .rst_i       (rst),
        .sample_i    (sample),
        .spi         (spi),
        .conv_start_o(conv_start),
        .conv_done_o (conv_done),
        .abort_o     (abort_p),
        .quiet_err_o (quiet_err)
    );

    always #5 clk = ~clk;

    int cmp = 0;
    int err = 0;
    int n_start = 0, n_done = 0, n_abort = 0, n_qerr = 0, n_both = 0;

    // pulse counters, sampled mid-cycle
    always @(negedge clk) begin
        if (!rst) begin
            n_start = n_start + int'(conv_start);
            n_done  = n_done  + int'(conv_done);
            n_abort = n_abort + int'(abort_p);
            n_qerr  = n_qerr  + int'(quiet_err);
            n_both  = n_both  + int'(quiet_err && conv_start);
        end
    end

    // One master transaction: bit 15 read before the first fall, bit 15-k
    // read at the rising edge following fall k. Releases cs_n at the end.
    task automatic run_frame(input logic [11:0] smp, input int nfalls,
                             input bit chg, input logic [11:0] alt,
                             output logic [15:0] bits,
                             output logic oe_a, output logic oe_b);
        bit seen;
        bits = '0;
        oe_a = 1'b0;
        oe_b = 1'b1;
        sample = smp;
        @(negedge clk);
        spi.cs_n = 1'b0;
        if (chg) begin
            seen = 1'b0;
            for (int i = 0; i < 20 && !seen; i++) begin
                @(negedge clk);
                if (conv_start === 1'b1) seen = 1'b1;
            end
            cmp++;
            if (!seen) begin
                err++;
                $display("FAIL conv_start_wait: got no pulse, want one within 20 cycles");
            end
            @(negedge clk);
            sample = alt;
        end else begin
            repeat (6) @(negedge clk);
        end
        bits[15] = spi.sdata;
        for (int k = 1; k <= nfalls; k++) begin
            spi.sclk = 1'b0;
            @(negedge clk);
            if (k == 16) oe_a = spi.sdata_oe;
            repeat (3) @(negedge clk);
            if (k == 16) oe_b = spi.sdata_oe;
            @(negedge clk);
            spi.sclk = 1'b1;
            if (k <= 15) bits[15-k] = spi.sdata;
            repeat (5) @(negedge clk);
        end
        spi.cs_n = 1'b1;
        repeat (2) @(negedge clk);
    endtask

    task automatic test_reset();
        rst = 1'b1;
        repeat (3) @(negedge clk);
        cmp++;
        if (spi.sdata_oe !== 1'b0) begin
            err++; $display("FAIL reset_oe: got %b want 0", spi.sdata_oe);
        end
        cmp++;
        if (spi.sdata !== 1'b0) begin
            err++; $display("FAIL reset_sdata: got %b want 0", spi.sdata);
        end
        cmp++;
        if ({conv_start, conv_done, abort_p, quiet_err} !== 4'b0000) begin
            err++;
            $display("FAIL reset_pulses: got %b want 0000",
                     {conv_start, conv_done, abort_p, quiet_err});
        end
        rst = 1'b0;
        repeat (5) @(negedge clk);
    endtask

    task automatic test_loopback();
        logic [11:0] vals[8];
        logic [15:0] bits;
        logic        oa, ob;
        int          s0, d0, a0;
        vals[0] = 12'hBA5;
        vals[1] = 12'h801;
        for (int i = 2; i < 8; i++) vals[i] = 12'($urandom);
        for (int i = 0; i < 8; i++) begin
            s0 = n_start; d0 = n_done; a0 = n_abort;
            run_frame(vals[i], 16, 1'b0, 12'h000, bits, oa, ob);
            repeat (20) @(negedge clk);
            cmp++;
            if (bits !== {4'h0, vals[i]}) begin
                err++; $display("FAIL loop_bits[%0d]: got %h want %h", i, bits, {4'h0, vals[i]});
            end
            cmp++;
            if (n_start - s0 != 1 || n_done - d0 != 1 || n_abort - a0 != 0) begin
                err++;
                $display("FAIL loop_pulses[%0d]: got start=%0d done=%0d abort=%0d want 1 1 0",
                         i, n_start - s0, n_done - d0, n_abort - a0);
            end
            cmp++;
            if (oa !== 1'b1 || ob !== 1'b0) begin
                err++; $display("FAIL loop_oe_drop[%0d]: got early=%b late=%b want 1 0", i, oa, ob);
            end
            cmp++;
            if (spi.sdata_oe !== 1'b0 || spi.sdata !== 1'b0) begin
                err++;
                $display("FAIL loop_idle[%0d]: got oe=%b sdata=%b want 0 0", i, spi.sdata_oe, spi.sdata);
            end
        end
    endtask

    task automatic test_early_release();
        logic [15:0] bits;
        logic        oa, ob;
        int          d0, a0;
        d0 = n_done; a0 = n_abort;
        run_frame(12'($urandom), 7, 1'b0, 12'h000, bits, oa, ob);
        repeat (20) @(negedge clk);
        cmp++;
        if (n_abort - a0 != 1 || n_done - d0 != 0) begin
            err++;
            $display("FAIL early_pulses: got abort=%0d done=%0d want 1 0", n_abort - a0, n_done - d0);
        end
        cmp++;
        if (spi.sdata_oe !== 1'b0) begin
            err++; $display("FAIL early_oe: got %b want 0", spi.sdata_oe);
        end
        run_frame(12'h123, 16, 1'b0, 12'h000, bits, oa, ob);
        repeat (20) @(negedge clk);
        cmp++;
        if (bits !== 16'h0123) begin
            err++; $display("FAIL early_next_bits: got %h want 0123", bits);
        end
    endtask

    task automatic test_quiet_violation();
        logic [15:0] bits;
        logic        oa, ob;
        int          q0, b0, s0;
        run_frame(12'($urandom), 16, 1'b0, 12'h000, bits, oa, ob);
        q0 = n_qerr; b0 = n_both; s0 = n_start;
        // restart three cycles after the release, well inside the quiet time
        run_frame(12'hFFF, 16, 1'b0, 12'h000, bits, oa, ob);
        repeat (20) @(negedge clk);
        cmp++;
        if (n_qerr - q0 != 1 || n_both - b0 != 1 || n_start - s0 != 1) begin
            err++;
            $display("FAIL quiet_pulses: got qerr=%0d coincident=%0d start=%0d want 1 1 1",
                     n_qerr - q0, n_both - b0, n_start - s0);
        end
        cmp++;
        if (bits !== 16'h0FFF) begin
            err++; $display("FAIL quiet_bits: got %h want 0fff", bits);
        end
        q0 = n_qerr;
        run_frame(12'($urandom), 16, 1'b0, 12'h000, bits, oa, ob);
        repeat (20) @(negedge clk);
        cmp++;
        if (n_qerr - q0 != 0) begin
            err++; $display("FAIL quiet_legal: got qerr=%0d want 0", n_qerr - q0);
        end
    endtask

    task automatic test_sample_capture();
        logic [15:0] bits;
        logic        oa, ob;
        run_frame(12'h0F0, 16, 1'b1, 12'hF0F, bits, oa, ob);
        repeat (20) @(negedge clk);
        cmp++;
        if (bits !== 16'h00F0) begin
            err++; $display("FAIL capture_bits: got %h want 00f0", bits);
        end
    endtask

    task automatic test_reset_mid_frame();
        logic [15:0] bits;
        logic        oa, ob;
        int          a0, d0;
        a0 = n_abort;
        sample = 12'($urandom);
        @(negedge clk);
        spi.cs_n = 1'b0;
        repeat (6) @(negedge clk);
        for (int k = 1; k <= 10; k++) begin
            spi.sclk = 1'b0;
            repeat (5) @(negedge clk);
            spi.sclk = 1'b1;
            repeat (5) @(negedge clk);
        end
        cmp++;
        if (spi.sdata_oe !== 1'b1) begin
            err++; $display("FAIL midrst_pre_oe: got %b want 1", spi.sdata_oe);
        end
        #2 rst = 1'b1;
        #1;
        cmp++;
        if (spi.sdata_oe !== 1'b0 || spi.sdata !== 1'b0 || abort_p !== 1'b0) begin
            err++;
            $display("FAIL midrst_outputs: got oe=%b sdata=%b abort=%b want 0 0 0",
                     spi.sdata_oe, spi.sdata, abort_p);
        end
        spi.cs_n = 1'b1;
        repeat (5) @(negedge clk);
        rst = 1'b0;
        repeat (20) @(negedge clk);
        cmp++;
        if (n_abort - a0 != 0) begin
            err++; $display("FAIL midrst_abort: got %0d want 0", n_abort - a0);
        end
        d0 = n_done;
        run_frame(12'h555, 16, 1'b0, 12'h000, bits, oa, ob);
        repeat (20) @(negedge clk);
        cmp++;
        if (bits !== 16'h0555 || n_done - d0 != 1) begin
            err++;
            $display("FAIL midrst_next: got bits=%h done=%0d want 0555 1", bits, n_done - d0);
        end
    endtask

    initial begin
        spi.sclk = 1'b1;
        spi.cs_n = 1'b1;
        test_reset();
        test_loopback();
        test_early_release();
        test_quiet_violation();
        test_sample_capture();
        test_reset_mid_frame();
        $display("*** SUMMARY: %0d compared / %0d mismatched ***", cmp, err);
        $finish;
    end

endmodule
